// File: rtl/dcache_pkg.sv
// Shared dcache definitions: memory request size codes and the memory-side responder FSM state.
package dcache_pkg;

  localparam logic [2:0] CACHE_MEM_REQ_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_HALF  = 3'b001;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_WORD  = 3'b010;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_DWORD = 3'b011;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_LINE  = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StIssue,
    StWaitResp,
    StDone
  } mem_responder_state_t;

  // Number of SRAM beats a request needs; reserved codes fall back to one beat.
  function automatic int unsigned mem_req_beats(input logic [2:0]  size,
                                                input int unsigned line_words);
    int unsigned beats;
    case (size)
      CACHE_MEM_REQ_SIZE_LINE:  beats = line_words;
      CACHE_MEM_REQ_SIZE_DWORD: beats = 2;
      default:                  beats = 1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache: turns line/word requests into a sequence of
// single-outstanding beats on a grant/valid word SRAM port, answering with ack then done.
module dcache_mem_responder #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [2:0]              size_i,
  input  logic [LINE_WIDTH-1:0]   wdata_i,
  input  logic [LINE_WIDTH/8-1:0] be_i,
  output logic                    ack_o,
  output logic                    done_o,
  output logic [LINE_WIDTH-1:0]   rdata_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [XLEN-1:0]         sram_wdata_o,
  output logic [XLEN/8-1:0]       sram_be_o,
  input  logic                    sram_gnt_i,
  input  logic                    sram_rvalid_i,
  input  logic [XLEN-1:0]         sram_rdata_i
);
  import dcache_pkg::*;

  localparam int unsigned LineBytes = LINE_WIDTH / 8;
  localparam int unsigned WordBytes = XLEN / 8;
  localparam int unsigned NumWords  = LINE_WIDTH / XLEN;
  localparam int unsigned WordIdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned WordOffW  = $clog2(WordBytes);
  localparam int unsigned LineOffW  = $clog2(LineBytes);
  localparam int unsigned TagW      = ADDR_WIDTH - LineOffW;

  mem_responder_state_t state_q, state_d;

  logic                    we_q;
  logic [TagW-1:0]         line_q;
  logic [WordIdxW-1:0]     start_w_q;
  logic [WordIdxW-1:0]     last_beat_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH/8-1:0] be_q;
  logic [WordIdxW-1:0]     beat_q, beat_d;
  logic [LINE_WIDTH-1:0]   rdata_q;

  logic                    capture;
  logic [WordIdxW-1:0]     plan_start_w;
  logic [WordIdxW-1:0]     plan_last_beat;
  logic [WordIdxW-1:0]     cur_w;
  logic                    issuing;
  logic                    rd_write;

  // Byte offset inside a word never selects a beat; only the word index matters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[WordOffW-1:0];

  // Beat plan. Line refills start at word 0; everything else starts at the addressed
  // word, so a dword at the last word of a line wraps to word 0 of the same line.
  always_comb begin
    plan_last_beat = WordIdxW'(mem_req_beats(size_i, NumWords) - 1);
    if (size_i == CACHE_MEM_REQ_SIZE_LINE) begin
      plan_start_w = '0;
    end else begin
      plan_start_w = addr_i[LineOffW-1:WordOffW];
    end
  end

  assign capture  = (state_q == StIdle) && req_i;
  assign cur_w    = start_w_q + beat_q;
  assign issuing  = (state_q == StAck) || (state_q == StIssue);
  assign rd_write = (state_q == StWaitResp) && sram_rvalid_i && !we_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StAck;
        end
      end
      // ACK already presents the first beat, so a same-cycle grant skips ISSUE.
      StAck, StIssue: begin
        if (sram_gnt_i) begin
          state_d = StWaitResp;
        end else begin
          state_d = StIssue;
        end
      end
      StWaitResp: begin
        if (sram_rvalid_i) begin
          if (beat_q == last_beat_q) begin
            state_d = StDone;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      we_q        <= 1'b0;
      line_q      <= '0;
      start_w_q   <= '0;
      last_beat_q <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (capture) begin
        we_q        <= we_i;
        line_q      <= addr_i[ADDR_WIDTH-1:LineOffW];
        start_w_q   <= plan_start_w;
        last_beat_q <= plan_last_beat;
        wdata_q     <= wdata_i;
        be_q        <= be_i;
        beat_q      <= '0;
        rdata_q     <= '0;
      end else if (rd_write) begin
        rdata_q[cur_w*XLEN +: XLEN] <= sram_rdata_i;
      end
    end
  end

  always_comb begin
    ack_o        = (state_q == StAck);
    done_o       = (state_q == StDone);
    rdata_o      = rdata_q;
    sram_req_o   = issuing;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (issuing) begin
      sram_we_o    = we_q;
      sram_addr_o  = {line_q, cur_w, {WordOffW{1'b0}}};
      sram_wdata_o = wdata_q[cur_w*XLEN +: XLEN];
      sram_be_o    = we_q ? be_q[cur_w*WordBytes +: WordBytes] : '1;
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed, table-driven bench for dcache_mem_responder with a stallable word-SRAM model.
module tb_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [2:0]   size;
  logic [127:0] wdata;
  logic [15:0]  be;
  logic         ack;
  logic         done;
  logic [127:0] rdata;
  logic         sram_req;
  logic         sram_we;
  logic [31:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic [3:0]   sram_be;
  logic         sram_gnt;
  logic         sram_rvalid;
  logic [31:0]  sram_rdata;

  dcache_mem_responder #(
    .LINE_WIDTH(128),
    .XLEN      (32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .size_i       (size),
    .wdata_i      (wdata),
    .be_i         (be),
    .ack_o        (ack),
    .done_o       (done),
    .rdata_o      (rdata),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_gnt_i   (sram_gnt),
    .sram_rvalid_i(sram_rvalid),
    .sram_rdata_i (sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // SRAM model knobs (written by the stimulus) and beat log (written by the model)
  int          gnt_stall = 0;
  int          rv_stall = 0;
  int          block_beat = 0;
  int          g_base = 0;
  int          inj_req = 0;
  int          inj_ack = 0;
  int          gcount = 0;
  int          gnt_cnt = 0;
  int          rv_cnt = 0;
  int          stab_err = 0;
  logic [1:0]  pend_w = '0;
  logic        prev_wait = 1'b0;
  logic [68:0] prev_fields = '0;
  logic [7:0]  gidx;
  logic [31:0] mem [4];
  logic [31:0] log_addr [256];
  logic        log_we [256];
  logic [3:0]  log_be [256];
  logic [31:0] log_wd [256];

  initial begin
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  end

  // Responses and grants change on the falling edge so the DUT sees them stable at posedge.
  always @(negedge clk) begin
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    if (rst) begin
      gnt_cnt = 0;
      rv_cnt  = 0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          sram_rvalid = 1'b1;
          sram_rdata  = mem[pend_w];
        end
      end
      if (inj_req != inj_ack) begin
        inj_ack = inj_req;
        if (!sram_rvalid) begin
          sram_rvalid = 1'b1;
          sram_rdata  = 32'hBAD0BAD0;
        end
      end
    end
    if (prev_wait && sram_req && ({sram_we, sram_addr, sram_wdata, sram_be} != prev_fields))
      stab_err++;
    sram_gnt = 1'b0;
    if (!rst && sram_req) begin
      if (gnt_cnt >= gnt_stall) begin
        sram_gnt = 1'b1;
        gnt_cnt  = 0;
        gidx = 8'(gcount);
        log_addr[gidx] = sram_addr;
        log_we[gidx]   = sram_we;
        log_be[gidx]   = sram_be;
        log_wd[gidx]   = sram_wdata;
        gcount++;
        if (gcount - g_base != block_beat) begin
          rv_cnt = rv_stall + 1;
          pend_w = sram_addr[3:2];
        end
      end else begin
        gnt_cnt++;
      end
    end
    prev_wait   = sram_req && !sram_gnt;
    prev_fields = {sram_we, sram_addr, sram_wdata, sram_be};
  end

  typedef struct {
    logic           we;
    logic [31:0]    addr;
    logic [2:0]     size;
    logic [127:0]   wdata;
    logic [15:0]    be;
    int             gs;
    int             rs;
    int             beats;
    logic [3:0][31:0] baddr;
    logic [3:0][3:0]  bbe;
    logic [3:0][31:0] bwd;
    logic [127:0]   rdata;
    int             done_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v, input int inj_at, input string tag);
    int k, ack_c, done_c, done_n, nb, base;
    logic [127:0] rd_done;
    logic [7:0] idx;
    @(negedge clk);
    gnt_stall = v.gs;
    rv_stall  = v.rs;
    g_base    = gcount;
    base      = gcount;
    we = v.we; addr = v.addr; size = v.size; wdata = v.wdata; be = v.be;
    req = 1'b1;
    k = cyc; ack_c = -1; done_c = -1; done_n = 0; rd_done = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cyc - k == inj_at) inj_req++;
      if (ack) begin
        if (ack_c < 0) ack_c = cyc - k;
        req = 1'b0;
      end
      if (done) begin
        done_n++;
        if (done_c < 0) begin
          done_c  = cyc - k;
          rd_done = rdata;
        end
      end
      if (done_c >= 0 && cyc - k >= done_c + 2) break;
    end
    req = 1'b0;
    nb = gcount - base;
    check({tag, " ack cycle"}, 128'(ack_c), 128'(1));
    check({tag, " done cycle"}, 128'(done_c), 128'(v.done_cyc));
    check({tag, " done pulses"}, 128'(done_n), 128'(1));
    check({tag, " beat count"}, 128'(nb), 128'(v.beats));
    check({tag, " rdata at done"}, rd_done, v.rdata);
    check({tag, " rdata held"}, rdata, v.rdata);
    for (int b = 0; b < v.beats && b < nb; b++) begin
      idx = 8'(base + b);
      check($sformatf("%s beat%0d addr", tag, b), 128'(log_addr[idx]), 128'(v.baddr[b]));
      check($sformatf("%s beat%0d we", tag, b), 128'(log_we[idx]), 128'(v.we));
      check($sformatf("%s beat%0d be", tag, b), 128'(log_be[idx]), 128'(v.bbe[b]));
      check($sformatf("%s beat%0d wdata", tag, b), 128'(log_wd[idx]), 128'(v.bwd[b]));
    end
  endtask

  vec_t vecs [8];
  vec_t vb;
  logic reached;
  logic bad;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    check("reset ack", 128'(ack), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset rdata", rdata, 128'(0));
    check("reset sram_req", 128'(sram_req), 128'(0));
    check("reset sram_be", 128'(sram_be), 128'(0));
    rst = 1'b0;

    vecs[0] = '{1'b0, 32'h8000_0014, 3'b111, 128'h0, 16'h0, 0, 0, 4,
                {32'h8000_001C, 32'h8000_0018, 32'h8000_0014, 32'h8000_0010},
                {4'hF, 4'hF, 4'hF, 4'hF}, 128'h0,
                128'h00000044_00000033_00000022_00000011, 9};
    vecs[1] = '{1'b1, 32'h8000_0020, 3'b111,
                128'h99AABBCC_55667788_11223344_DDCCBBAA, 16'hFFFF, 0, 0, 4,
                {32'h8000_002C, 32'h8000_0028, 32'h8000_0024, 32'h8000_0020},
                {4'hF, 4'hF, 4'hF, 4'hF},
                {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'hDDCCBBAA}, 128'h0, 9};
    vecs[2] = '{1'b1, 32'h8000_0006, 3'b000,
                128'h00000000_00000000_00AB0000_00000000, 16'h0040, 0, 0, 1,
                {32'h0, 32'h0, 32'h0, 32'h8000_0004}, {4'h0, 4'h0, 4'h0, 4'h4},
                {32'h0, 32'h0, 32'h0, 32'h00AB0000}, 128'h0, 3};
    vecs[3] = '{1'b0, 32'h8000_0108, 3'b010, 128'h0, 16'h0, 5, 3, 1,
                {32'h0, 32'h0, 32'h0, 32'h8000_0108}, {4'h0, 4'h0, 4'h0, 4'hF}, 128'h0,
                128'h00000000_00000033_00000000_00000000, 11};
    vecs[4] = '{1'b0, 32'h8000_000C, 3'b011, 128'h0, 16'h0, 0, 0, 2,
                {32'h0, 32'h0, 32'h8000_0000, 32'h8000_000C}, {4'h0, 4'h0, 4'hF, 4'hF}, 128'h0,
                128'h00000044_00000000_00000000_00000011, 5};
    vecs[5] = '{1'b1, 32'h8000_001A, 3'b001,
                128'h00000000_BEEF0000_00000000_00000000, 16'h0C00, 0, 2, 1,
                {32'h0, 32'h0, 32'h0, 32'h8000_0018}, {4'h0, 4'h0, 4'h0, 4'hC},
                {32'h0, 32'h0, 32'h0, 32'hBEEF0000}, 128'h0, 5};
    vecs[6] = '{1'b0, 32'h8000_0005, 3'b101, 128'h0, 16'h0, 0, 0, 1,
                {32'h0, 32'h0, 32'h0, 32'h8000_0004}, {4'h0, 4'h0, 4'h0, 4'hF}, 128'h0,
                128'h00000000_00000000_00000022_00000000, 3};
    vecs[7] = '{1'b1, 32'h4000_0030, 3'b111,
                128'h00000004_00000003_00000002_00000001, 16'h0000, 1, 1, 4,
                {32'h4000_003C, 32'h4000_0038, 32'h4000_0034, 32'h4000_0030},
                {4'h0, 4'h0, 4'h0, 4'h0},
                {32'h4, 32'h3, 32'h2, 32'h1}, 128'h0, 17};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], -1, $sformatf("v%0d", i));
    check("beat fields stable while stalled", 128'(stab_err), 128'(0));

    // Reset while waiting for the response of beat 2 of a refill.
    @(negedge clk);
    gnt_stall = 0; rv_stall = 0; g_base = gcount; block_beat = 2;
    we = 1'b0; addr = 32'h8000_0040; size = 3'b111; wdata = '0; be = '0; req = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) req = 1'b0;
      if (gcount - g_base == 2 && !sram_req) begin
        reached = 1'b1;
        break;
      end
    end
    req = 1'b0;
    check("rst reached beat2 wait", 128'(reached), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    block_beat = 0;
    check("rst ack", 128'(ack), 128'(0));
    check("rst done", 128'(done), 128'(0));
    check("rst rdata", rdata, 128'(0));
    check("rst sram_req", 128'(sram_req), 128'(0));
    check("rst sram_we", 128'(sram_we), 128'(0));
    check("rst sram_addr", 128'(sram_addr), 128'(0));
    check("rst sram_wdata", 128'(sram_wdata), 128'(0));
    check("rst sram_be", 128'(sram_be), 128'(0));
    inj_req++;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || ack || sram_req || rdata != '0) bad = 1'b1;
    end
    check("late rvalid ignored in idle", 128'(bad), 128'(0));
    run_vec(vecs[6], -1, "post_rst");

    // Stray rvalid while the beat is still waiting for its grant.
    vb = '{1'b0, 32'h8000_0008, 3'b010, 128'h0, 16'h0, 3, 0, 1,
           {32'h0, 32'h0, 32'h0, 32'h8000_0008}, {4'h0, 4'h0, 4'h0, 4'hF}, 128'h0,
           128'h00000000_00000033_00000000_00000000, 6};
    run_vec(vb, 2, "rv_in_issue_a");
    run_vec(vb, 3, "rv_in_issue_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
